// File: rtl/clk_divider_prog_if.sv
// Control and output bundle for clk_divider_prog: run/sync controls, ratio writes,
// per-channel pending flags and the divided clocks with their tick pulses.
interface clk_divider_prog_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    logic              en;
    logic              sync;
    logic              cfg_wr;
    logic [2:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    modport master (
        output en, sync, cfg_wr, cfg_ch, cfg_div,
        input  pend, clk_out, tick
    );

    modport slave (
        input  en, sync, cfg_wr, cfg_ch, cfg_div,
        output pend, clk_out, tick
    );
endinterface

// File: rtl/clk_divider_prog.sv
// Programmable multi-channel clock divider with ratio updates applied at period boundaries.
// Optional ODD_DUTY50_EN adds a negedge flop per channel for exact 50% duty on odd ratios.
module clk_divider_prog #(
    parameter int NUM_CH  = 2,
    parameter int CNT_W   = 8,
    parameter int RST_DIV = 4
) (
    input  logic              clk,
    input  logic              resetn,
    clk_divider_prog_if.slave bus
);

    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] clk_v;
    logic [NUM_CH-1:0] tick_v;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] pend_div;
        logic [CNT_W-1:0] cnt;
        logic             pend_r;
        logic             pos_hi;
        logic             tick_r;

        logic             wr_hit;
        logic             stopped;
        logic             wrap;
        logic             apply;
        logic             run_nxt;
        logic             pos_hi_nxt;
        logic             tick_nxt;
        logic [CNT_W-1:0] n_cur;
        logic [CNT_W-1:0] act_nxt;
        logic [CNT_W-1:0] n_new;
        logic [CNT_W-1:0] cnt_nxt;

        // A stopped channel treats every edge as a boundary so a pending ratio starts it at once;
        // outputs are computed from the ratio in force after this edge, so the apply edge uses the new N.
        always_comb begin
            wr_hit     = bus.cfg_wr && (bus.cfg_ch == 3'(c));
            n_cur      = (act_div == CNT_W'(1)) ? CNT_W'(2) : act_div;
            stopped    = (act_div == '0);
            wrap       = stopped || bus.sync || (cnt == n_cur - CNT_W'(1));
            apply      = wrap && pend_r;
            act_nxt    = apply ? pend_div : act_div;
            n_new      = (act_nxt == CNT_W'(1)) ? CNT_W'(2) : act_nxt;
            cnt_nxt    = wrap ? '0 : cnt + CNT_W'(1);
            run_nxt    = (act_nxt != '0);
            pos_hi_nxt = run_nxt && (cnt_nxt < (n_new >> 1));
            tick_nxt   = run_nxt && (cnt_nxt == '0);
        end

        // A write landing on the apply edge re-arms pending after the old value is consumed.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                act_div  <= CNT_W'(RST_DIV);
                pend_div <= CNT_W'(RST_DIV);
                cnt      <= CNT_W'(RST_DIV - 1);
                pend_r   <= 1'b0;
                pos_hi   <= 1'b0;
                tick_r   <= 1'b0;
            end else begin
                if (bus.en) begin
                    act_div <= act_nxt;
                    cnt     <= cnt_nxt;
                    pos_hi  <= pos_hi_nxt;
                    tick_r  <= tick_nxt;
                    if (apply) begin
                        pend_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end
                if (wr_hit) begin
                    pend_div <= bus.cfg_div;
                    pend_r   <= 1'b1;
                end
            end
        end

`ifdef ODD_DUTY50_EN
        logic neg_hi;

        // Half-cycle-delayed copy of the high phase, only for odd ratios.
        always_ff @(negedge clk or negedge resetn) begin
            if (!resetn) begin
                neg_hi <= 1'b0;
            end else begin
                neg_hi <= pos_hi & n_cur[0];
            end
        end

        assign clk_v[c] = pos_hi | neg_hi;
`else
        assign clk_v[c] = pos_hi;
`endif

        assign pend_v[c] = pend_r;
        assign tick_v[c] = tick_r;
    end

    assign bus.pend    = pend_v;
    assign bus.clk_out = clk_v;
    assign bus.tick    = tick_v;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed testbench for clk_divider_prog (NUM_CH=2, CNT_W=8, RST_DIV=4).
// Expected tables are hand-derived per edge after reset release; odd-duty tables switch on ODD_DUTY50_EN.
module tb_clk_divider_prog;
    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 8;
    localparam int RST_DIV = 4;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    clk_divider_prog_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    clk_divider_prog #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .RST_DIV(RST_DIV)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_reset();
        resetn      = 1'b0;
        bus.en      = 1'b1;
        bus.sync    = 1'b0;
        bus.cfg_wr  = 1'b0;
        bus.cfg_ch  = 3'd0;
        bus.cfg_div = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit pat_clk[9]  = '{1,1,0,0,1,1,0,0,1};
        bit pat_tick[9] = '{1,0,0,0,1,0,0,0,1};
        logic [5:0] exp_v;
        hold_reset();
        checks++;
        if ({bus.pend, bus.tick, bus.clk_out} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_state got=%b expected=%b", {bus.pend, bus.tick, bus.clk_out}, 6'b0);
        end
        resetn = 1'b1;
        for (int e = 0; e < 9; e++) begin
            next_edge();
            exp_v = {2'b00, {2{pat_tick[e]}}, {2{pat_clk[e]}}};
            checks++;
            if ({bus.pend, bus.tick, bus.clk_out} !== exp_v) begin
                failures++;
                $display("[TB] FAIL reset_release edge=%0d got=%b expected=%b", e + 1, {bus.pend, bus.tick, bus.clk_out}, exp_v);
            end
        end
    endtask

    task automatic test_ratio_change();
        bit c0clk[11] = '{1,1,0,0,1,1,1,0,0,0,1};
        bit c0tk[11]  = '{1,0,0,0,1,0,0,0,0,0,1};
        bit c1clk[11] = '{1,1,0,0,1,1,0,0,1,1,0};
        bit c1tk[11]  = '{1,0,0,0,1,0,0,0,1,0,0};
        bit p0[11]    = '{0,1,1,1,0,0,0,0,0,0,0};
        logic [5:0] exp_v;
        hold_reset();
        resetn = 1'b1;
        for (int e = 0; e < 11; e++) begin
            bus.cfg_wr  = (e == 1);
            bus.cfg_ch  = 3'd0;
            bus.cfg_div = 8'd6;
            next_edge();
            exp_v = {1'b0, p0[e], c1tk[e], c0tk[e], c1clk[e], c0clk[e]};
            checks++;
            if ({bus.pend, bus.tick, bus.clk_out} !== exp_v) begin
                failures++;
                $display("[TB] FAIL ratio_change edge=%0d got=%b expected=%b", e + 1, {bus.pend, bus.tick, bus.clk_out}, exp_v);
            end
        end
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_odd_ratio();
`ifdef ODD_DUTY50_EN
        bit pos_clk[15] = '{1,1,0,0,1,1,1,0,0,1,1,1,0,0,1};
`else
        bit pos_clk[15] = '{1,1,0,0,1,1,0,0,0,1,1,0,0,0,1};
`endif
        bit neg_clk[15] = '{1,1,0,0,1,1,0,0,0,1,1,0,0,0,1};
        bit tk[15]      = '{1,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
        bit p1[15]      = '{1,1,1,1,0,0,0,0,0,0,0,0,0,0,0};
        logic [2:0] exp_v;
        hold_reset();
        resetn = 1'b1;
        for (int e = 0; e < 15; e++) begin
            bus.cfg_wr  = (e == 0);
            bus.cfg_ch  = 3'd1;
            bus.cfg_div = 8'd5;
            next_edge();
            exp_v = {p1[e], tk[e], pos_clk[e]};
            checks++;
            if ({bus.pend[1], bus.tick[1], bus.clk_out[1]} !== exp_v) begin
                failures++;
                $display("[TB] FAIL odd_ratio_pos edge=%0d got=%b expected=%b", e + 1, {bus.pend[1], bus.tick[1], bus.clk_out[1]}, exp_v);
            end
            @(negedge clk);
            #1;
            checks++;
            if (bus.clk_out[1] !== neg_clk[e]) begin
                failures++;
                $display("[TB] FAIL odd_ratio_neg edge=%0d got=%b expected=%b", e + 1, bus.clk_out[1], neg_clk[e]);
            end
        end
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_stop_restart();
`ifdef ODD_DUTY50_EN
        bit c0clk[12] = '{1,1,0,0,0,0,0,0,1,1,0,1};
`else
        bit c0clk[12] = '{1,1,0,0,0,0,0,0,1,0,0,1};
`endif
        bit c0tk[12]  = '{1,0,0,0,0,0,0,0,1,0,0,1};
        bit p0[12]    = '{0,1,1,1,0,0,0,1,0,0,0,0};
        logic [2:0] exp_v;
        hold_reset();
        resetn = 1'b1;
        for (int e = 0; e < 12; e++) begin
            bus.cfg_wr  = (e == 1) || (e == 7);
            bus.cfg_ch  = 3'd0;
            bus.cfg_div = (e == 7) ? 8'd3 : 8'd0;
            next_edge();
            exp_v = {p0[e], c0tk[e], c0clk[e]};
            checks++;
            if ({bus.pend[0], bus.tick[0], bus.clk_out[0]} !== exp_v) begin
                failures++;
                $display("[TB] FAIL stop_restart edge=%0d got=%b expected=%b", e + 1, {bus.pend[0], bus.tick[0], bus.clk_out[0]}, exp_v);
            end
        end
        bus.cfg_wr = 1'b0;
    endtask

    task automatic test_sync();
        bit c0clk[20] = '{1,1,0,0, 1,1,0,0, 1,1,0,0, 1,1,0,1, 1,0,0,1};
        bit c0tk[20]  = '{1,0,0,0, 1,0,0,0, 1,0,0,0, 1,0,0,1, 0,0,0,1};
        bit c1clk[20] = '{1,1,0,0, 1,1,1,0, 0,0,1,1, 1,0,0,1, 1,1,0,0};
        bit c1tk[20]  = '{1,0,0,0, 1,0,0,0, 0,0,1,0, 0,0,0,1, 0,0,0,0};
        logic [3:0] exp_v;
        hold_reset();
        resetn = 1'b1;
        for (int e = 0; e < 20; e++) begin
            bus.cfg_wr  = (e == 0);
            bus.cfg_ch  = 3'd1;
            bus.cfg_div = 8'd6;
            bus.sync    = (e == 15);
            next_edge();
            exp_v = {c1tk[e], c0tk[e], c1clk[e], c0clk[e]};
            checks++;
            if ({bus.tick, bus.clk_out} !== exp_v) begin
                failures++;
                $display("[TB] FAIL sync_align edge=%0d got=%b expected=%b", e + 1, {bus.tick, bus.clk_out}, exp_v);
            end
        end
        bus.cfg_wr = 1'b0;
        bus.sync   = 1'b0;
    endtask

    task automatic test_enable_and_reset();
        logic [5:0] run_tab[11] = '{6'b00_11_11, 6'b10_00_11, 6'b10_00_11, 6'b10_00_11,
                                    6'b10_00_11, 6'b10_00_00, 6'b10_00_00, 6'b00_11_11,
                                    6'b00_00_11, 6'b00_00_10, 6'b00_00_00};
        logic [5:0] post_tab[5] = '{6'b00_11_11, 6'b00_00_11, 6'b00_00_00, 6'b00_00_00, 6'b00_11_11};
        hold_reset();
        resetn = 1'b1;
        // Frozen for edges 2-4 while a ch1 ratio write is accepted
        for (int e = 0; e < 11; e++) begin
            bus.en      = !(e >= 1 && e <= 3);
            bus.cfg_wr  = (e == 1);
            bus.cfg_ch  = 3'd1;
            bus.cfg_div = 8'd6;
            next_edge();
            checks++;
            if ({bus.pend, bus.tick, bus.clk_out} !== run_tab[e]) begin
                failures++;
                $display("[TB] FAIL enable_hold edge=%0d got=%b expected=%b", e + 1, {bus.pend, bus.tick, bus.clk_out}, run_tab[e]);
            end
        end
        bus.en      = 1'b1;
        bus.cfg_wr  = 1'b1;
        bus.cfg_ch  = 3'd0;
        bus.cfg_div = 8'd2;
        next_edge();
        bus.cfg_wr = 1'b0;
        checks++;
        if (bus.pend !== 2'b01) begin
            failures++;
            $display("[TB] FAIL pend_before_reset got=%b expected=%b", bus.pend, 2'b01);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if ({bus.pend, bus.tick, bus.clk_out} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL async_reset got=%b expected=%b", {bus.pend, bus.tick, bus.clk_out}, 6'b0);
        end
        resetn = 1'b1;
        for (int e = 0; e < 5; e++) begin
            next_edge();
            checks++;
            if ({bus.pend, bus.tick, bus.clk_out} !== post_tab[e]) begin
                failures++;
                $display("[TB] FAIL after_reset edge=%0d got=%b expected=%b", e + 1, {bus.pend, bus.tick, bus.clk_out}, post_tab[e]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ratio_change();
        test_odd_ratio();
        test_stop_restart();
        test_sync();
        test_enable_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end
endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Programmable multi-channel clock divider for generating slow derived clocks and matching single-cycle enable ticks from one reference clock. Each channel has an independent, runtime-writable divide ratio. Ratio changes take effect glitch-free at the channel's period boundary. A global sync pulse phase-aligns all channels. It replaces fixed power-of-two divider chains in the clocking/timebase area of the design.

## Interface
- NUM_CH, 2, number of independent divider channels (1..8)
- CNT_W, 8, counter and ratio width; maximum ratio 2^CNT_W-1
- RST_DIV, 4, ratio loaded into every channel at reset (2..2^CNT_W-1)

Ports:
- clk  input  1  reference clock
- resetn  input  1  reset; asynchronous, active-low
- en  input  1  global run enable
- sync  input  1  one-cycle pulse; restarts all running channels in phase
- cfg_wr  input  1  ratio write strobe
- cfg_ch  input  3  target channel for cfg_wr; values >= NUM_CH are ignored
- cfg_div  input  CNT_W  new divide ratio N
- pend  output  NUM_CH  per channel: written ratio not yet applied
- clk_out  output  NUM_CH  divided clocks
- tick  output  NUM_CH  one-clk pulse coincident with each clk_out rising edge

## Operation
- Reset values: every active ratio = RST_DIV, every pending ratio = RST_DIV, pend = 0, clk_out = 0, tick = 0, every cnt = RST_DIV-1.
- Ratio mapping: N=0 stops the channel, with clk_out=0 and tick=0. N=1 is treated as N=2.
- Per channel, on each clk posedge with en=1 and N>=2: cnt_next = (cnt==N-1) ? 0 : cnt+1. Outputs are registered: clk_out <= (cnt_next < floor(N/2)), tick <= (cnt_next==0).
- High phase is floor(N/2) cycles and low phase is ceil(N/2) cycles. Even N gives exactly 50% duty.
- cfg_wr stores cfg_div into the channel's pending register and sets pend.
  - The pending ratio becomes active on the edge where cnt wraps N-1 -> 0. That edge itself already uses the new N for the outputs. pend then clears.
  - If the channel is stopped (active N=0), the ratio applies on the next edge and cnt restarts at 0 on that edge.
  - A write while pend=1 overwrites the pending value. Only the last write applies.
- cfg_wr to a channel on the same edge as its wrap: the old pending value (if any) applies and the new value becomes pending.
- sync=1 (with en=1): all running channels load cnt_next=0 on that edge, so tick=1 and clk_out=1 on all of them. Any pending ratio applies at the same time. sync has priority over normal counting.
- en=0: counters, outputs and pending ratios hold their values. tick is forced to 0. Writes are still accepted.
- Mid-operation reset: asynchronously returns all state to its reset values, discarding pending writes.

## Timing
- Latency from reset release: the first posedge gives cnt=0, clk_out=1, tick=1.
- Example N=4: clk_out is high after edges 1-2 and low after edges 3-4. tick fires at edges 1, 5, 9, ...
- cfg_wr to first period at the new ratio: the remaining cycles of the current period plus 1 edge. No runt or stretched pulse is ever produced.
- sync to aligned outputs: the same edge. All channels rise together 1 clk after sync is sampled.
- pend asserts 1 clk after cfg_wr and deasserts on the apply edge.

## Configuration
- ODD_DUTY50_EN defined:
  - For odd N, each channel adds a negedge-clocked flop holding the posedge high term.
  - clk_out = pos_hi | neg_hi, which extends the high phase by half a clk. Duty is exactly 50% (N/2 cycles high).
  - For even N, neg_hi is masked to 0.
  - clk_out becomes combinational from two flops; tick is unchanged.
- Undefined: purely posedge logic with a registered clk_out. Odd N gives floor(N/2) high and ceil(N/2) low.

## Test plan
- Reset release with RST_DIV=4, en=1 -> clk_out[0] pattern 1,1,0,0 repeating from edge 1; tick at edges 1, 5, 9.
- Write N=6 to ch0 at edge 2 -> pend[0]=1 until edge 5; ticks at edges 5 and 11; high for 3 cycles and low for 3; no glitch at the boundary.
- Write N=5 to ch1 -> high 2 cycles, low 3 cycles. With ODD_DUTY50_EN: high 2.5 cycles, measured on both clk edges.
- Write N=0 then N=3 to ch0 -> clk_out/tick held 0 after the wrap; restart with tick on the edge after the N=3 write.
- ch0 N=4, ch1 N=6 out of phase, then pulse sync -> both tick on the sync edge and clk_out rises together.
- en=0 for 3 cycles mid-period, and separately resetn asserted mid-period -> outputs frozen with tick=0 then continue; reset clears clk_out, pend and the ratios to RST_DIV immediately.
